// File: rtl/mont_host_driver_if.sv
// Handshake bundle between the Montgomery host driver and the wrapper.
// Master is the initiator; slave is the responding wrapper.
interface mont_host_driver_if;
  logic [31:0]  port1_dout;
  logic         port1_valid;
  logic         port1_read;
  logic [511:0] bram_din1;
  logic [511:0] bram_din2;
  logic         bram_din_valid;
  logic [511:0] bram_dout1;
  logic [511:0] bram_dout2;
  logic         bram_dout1_valid;
  logic         bram_dout2_valid;
  logic         bram_dout_read;
  logic         port2_valid;
  logic         port2_read;

  modport master (
    output port1_dout, port1_valid,
    output bram_din1, bram_din2, bram_din_valid,
    output bram_dout_read, port2_read,
    input  port1_read,
    input  bram_dout1, bram_dout2,
    input  bram_dout1_valid, bram_dout2_valid,
    input  port2_valid
  );

  modport slave (
    input  port1_dout, port1_valid,
    input  bram_din1, bram_din2, bram_din_valid,
    input  bram_dout_read, port2_read,
    output port1_read,
    output bram_dout1, bram_dout2,
    output bram_dout1_valid, bram_dout2_valid,
    output port2_valid
  );
endinterface

// File: rtl/mont_host_driver.sv
// Hardware initiator for the Montgomery wrapper command protocol:
// READ_A, READ_B, READ_M, MULTIPLY, WRITE with per-state timeout.
module mont_host_driver #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] a1,
  input  logic [511:0] a2,
  input  logic [511:0] b1,
  input  logic [511:0] b2,
  input  logic [511:0] m1,
  input  logic [511:0] m2,
  output logic [511:0] res1,
  output logic [511:0] res2,
  output logic         done,
  output logic         busy,
  output logic         err,
  mont_host_driver_if.master bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CMD      = 3'd1;
  localparam logic [2:0] S_DATA     = 3'd2;
  localparam logic [2:0] S_WAITDONE = 3'd3;
  localparam logic [2:0] S_RESULT   = 3'd4;
  localparam logic [2:0] S_P2ACK    = 3'd5;
  localparam logic [2:0] S_P2LOW    = 3'd6;
  localparam logic [2:0] S_FIN      = 3'd7;

  localparam logic [16:0] TMO = 17'(TIMEOUT_CYCLES);

  logic [2:0]   state;
  logic [2:0]   cmd_idx;
  logic [16:0]  cnt;
  logic         got;
  logic         timed;
  logic         tmo;
  logic [511:0] ra1, ra2;
  logic [511:0] rb1, rb2;
  logic [511:0] rm1, rm2;

  assign timed = (state == S_CMD)
              || (state == S_DATA)
              || (state == S_WAITDONE)
              || (state == S_RESULT)
              || (state == S_P2LOW);

  assign tmo = timed && (cnt == TMO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      cmd_idx              <= 3'd0;
      cnt                  <= '0;
      got                  <= 1'b0;
      ra1                  <= '0;
      ra2                  <= '0;
      rb1                  <= '0;
      rb2                  <= '0;
      rm1                  <= '0;
      rm2                  <= '0;
      res1                 <= '0;
      res2                 <= '0;
      done                 <= 1'b0;
      busy                 <= 1'b0;
      err                  <= 1'b0;
      bus.port1_dout       <= '0;
      bus.port1_valid      <= 1'b0;
      bus.bram_din1        <= '0;
      bus.bram_din2        <= '0;
      bus.bram_din_valid   <= 1'b0;
      bus.bram_dout_read   <= 1'b0;
      bus.port2_read       <= 1'b0;
    end else begin
      bus.bram_dout_read <= 1'b0;
      // counter runs in wait states; every transition below clears it
      cnt <= timed ? cnt + 17'd1 : '0;
      if (tmo) begin
        err                <= 1'b1;
        done               <= 1'b1;
        bus.port1_valid    <= 1'b0;
        bus.bram_din_valid <= 1'b0;
        bus.port2_read     <= 1'b0;
        cnt                <= '0;
        state              <= S_FIN;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              ra1             <= a1;
              ra2             <= a2;
              rb1             <= b1;
              rb2             <= b2;
              rm1             <= m1;
              rm2             <= m2;
              cmd_idx         <= 3'd0;
              err             <= 1'b0;
              busy            <= 1'b1;
              bus.port1_dout  <= '0;
              bus.port1_valid <= 1'b1;
              cnt             <= '0;
              state           <= S_CMD;
            end
          end
          S_CMD: begin
            if (!bus.port1_valid) begin
              bus.port1_valid <= 1'b1;
            end else if (bus.port1_read) begin
              bus.port1_valid <= 1'b0;
              cnt             <= '0;
              unique case (1'b1)
                (cmd_idx == 3'd0): begin
                  bus.bram_din1      <= ra1;
                  bus.bram_din2      <= ra2;
                  bus.bram_din_valid <= 1'b1;
                  state              <= S_DATA;
                end
                (cmd_idx == 3'd1): begin
                  bus.bram_din1      <= rb1;
                  bus.bram_din2      <= rb2;
                  bus.bram_din_valid <= 1'b1;
                  state              <= S_DATA;
                end
                (cmd_idx == 3'd2): begin
                  bus.bram_din1      <= rm1;
                  bus.bram_din2      <= rm2;
                  bus.bram_din_valid <= 1'b1;
                  state              <= S_DATA;
                end
                (cmd_idx == 3'd3): begin
                  state <= S_WAITDONE;
                end
                default: begin
                  got   <= 1'b0;
                  state <= S_RESULT;
                end
              endcase
            end
          end
          S_DATA: begin
            if (bus.port2_valid) begin
              bus.bram_din_valid <= 1'b0;
              bus.port2_read     <= 1'b1;
              cnt                <= '0;
              state              <= S_P2ACK;
            end
          end
          S_WAITDONE: begin
            if (bus.port2_valid) begin
              bus.port2_read <= 1'b1;
              cnt            <= '0;
              state          <= S_P2ACK;
            end
          end
          S_RESULT: begin
            if (!got) begin
              if (bus.bram_dout1_valid && bus.bram_dout2_valid) begin
                res1               <= bus.bram_dout1;
                res2               <= bus.bram_dout2;
                bus.bram_dout_read <= 1'b1;
                got                <= 1'b1;
              end
            end else if (bus.port2_valid) begin
              bus.port2_read <= 1'b1;
              cnt            <= '0;
              state          <= S_P2ACK;
            end
          end
          S_P2ACK: begin
            bus.port2_read <= 1'b0;
            state          <= S_P2LOW;
          end
          S_P2LOW: begin
            // a late-dropping port2_valid must not be taken as a new done
            if (!bus.port2_valid) begin
              cnt <= '0;
              if (cmd_idx == 3'd4) begin
                done  <= 1'b1;
                state <= S_FIN;
              end else begin
                cmd_idx        <= cmd_idx + 3'd1;
                bus.port1_dout <= {29'd0, cmd_idx + 3'd1};
                state          <= S_CMD;
              end
            end
          end
          default: begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mont_host_driver.sv
// Directed bench: one responder model drives either the default DUT
// or a short-timeout instance selected by sel.
module tb_mont_host_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sel = 1'b0;
  logic r_start = 1'b0;
  logic r_p1_read = 1'b0;
  logic r_d1v = 1'b0;
  logic r_d2v = 1'b0;
  logic r_p2v = 1'b0;
  logic [511:0] r_dout1 = '0;
  logic [511:0] r_dout2 = '0;
  logic [511:0] op_a1 = '0, op_a2 = '0, op_b1 = '0;
  logic [511:0] op_b2 = '0, op_m1 = '0, op_m2 = '0;

  logic [511:0] res1_a, res2_a, res1_b, res2_b;
  logic done_a, busy_a, err_a, done_b, busy_b, err_b;
  logic start_a, start_b;

  int vecs = 0;
  int miss = 0;
  int done_cnt = 0;
  int cmd_cnt = 0;
  int p2r_cnt = 0;
  logic p1v_prev = 1'b0;

  mont_host_driver_if bus();
  mont_host_driver_if bus_t();

  always #5 clk = ~clk;

  assign start_a = r_start & ~sel;
  assign start_b = r_start & sel;

  assign bus.port1_read         = r_p1_read & ~sel;
  assign bus.bram_dout1         = r_dout1;
  assign bus.bram_dout2         = r_dout2;
  assign bus.bram_dout1_valid   = r_d1v & ~sel;
  assign bus.bram_dout2_valid   = r_d2v & ~sel;
  assign bus.port2_valid        = r_p2v & ~sel;
  assign bus_t.port1_read       = r_p1_read & sel;
  assign bus_t.bram_dout1       = r_dout1;
  assign bus_t.bram_dout2       = r_dout2;
  assign bus_t.bram_dout1_valid = r_d1v & sel;
  assign bus_t.bram_dout2_valid = r_d2v & sel;
  assign bus_t.port2_valid      = r_p2v & sel;

  mont_host_driver dut (
    .clk(clk), .reset(reset), .start(start_a),
    .a1(op_a1), .a2(op_a2), .b1(op_b1),
    .b2(op_b2), .m1(op_m1), .m2(op_m2),
    .res1(res1_a), .res2(res2_a),
    .done(done_a), .busy(busy_a), .err(err_a),
    .bus(bus)
  );

  mont_host_driver #(.TIMEOUT_CYCLES(50)) dut_t (
    .clk(clk), .reset(reset), .start(start_b),
    .a1(op_a1), .a2(op_a2), .b1(op_b1),
    .b2(op_b2), .m1(op_m1), .m2(op_m2),
    .res1(res1_b), .res2(res2_b),
    .done(done_b), .busy(busy_b), .err(err_b),
    .bus(bus_t)
  );

  logic [31:0]  o_p1_dout;
  logic         o_p1v, o_dinv, o_dread, o_p2r;
  logic         o_done, o_busy, o_err;
  logic [511:0] o_din1, o_din2, o_res1, o_res2;

  assign o_p1_dout = sel ? bus_t.port1_dout : bus.port1_dout;
  assign o_p1v     = sel ? bus_t.port1_valid : bus.port1_valid;
  assign o_dinv    = sel ? bus_t.bram_din_valid : bus.bram_din_valid;
  assign o_dread   = sel ? bus_t.bram_dout_read : bus.bram_dout_read;
  assign o_p2r     = sel ? bus_t.port2_read : bus.port2_read;
  assign o_din1    = sel ? bus_t.bram_din1 : bus.bram_din1;
  assign o_din2    = sel ? bus_t.bram_din2 : bus.bram_din2;
  assign o_done    = sel ? done_b : done_a;
  assign o_busy    = sel ? busy_b : busy_a;
  assign o_err     = sel ? err_b : err_a;
  assign o_res1    = sel ? res1_b : res1_a;
  assign o_res2    = sel ? res2_b : res2_a;

  always @(posedge clk) begin
    if (o_done) done_cnt++;
    if (o_p2r) p2r_cnt++;
    if (o_p1v && !p1v_prev) cmd_cnt++;
    p1v_prev = o_p1v;
  end

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int a1, input int b1, input int m1,
                         input int a2, input int b2, input int m2);
    op_a1 = 512'(a1); op_b1 = 512'(b1); op_m1 = 512'(m1);
    op_a2 = 512'(a2); op_b2 = 512'(b2); op_m2 = 512'(m2);
  endtask

  task automatic pulse_start();
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
  endtask

  // lat < 0: never signal completion for this command
  task automatic serve(input int idx, input int rd_delay, input int lat,
                       input int hold, input bit poke);
    int n;
    bit held;
    logic [511:0] s1, s2, s3, s4, s5, s6;
    n = 0;
    while (o_p1v !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_valid", o_p1v, 1);
    chk("cmd_word", o_p1_dout, 512'(idx));
    held = 1'b1;
    repeat (rd_delay) begin
      @(negedge clk);
      held &= (o_p1v === 1'b1) && (o_p1_dout === 32'(idx));
    end
    if (rd_delay > 0) chk("cmd_hold", held, 1);
    r_p1_read = 1'b1;
    @(negedge clk);
    r_p1_read = 1'b0;
    chk("cmd_drop", o_p1v, 0);
    if (idx < 3) begin
      chk("din_valid", o_dinv, 1);
      chk("din1", o_din1, idx == 0 ? op_a1 : idx == 1 ? op_b1 : op_m1);
      chk("din2", o_din2, idx == 0 ? op_a2 : idx == 1 ? op_b2 : op_m2);
      if (poke) begin
        s1 = op_a1; s2 = op_a2; s3 = op_b1;
        s4 = op_b2; s5 = op_m1; s6 = op_m2;
        set_ops(99, 98, 97, 96, 95, 94);
        pulse_start();
        op_a1 = s1; op_a2 = s2; op_b1 = s3;
        op_b2 = s4; op_m1 = s5; op_m2 = s6;
        chk("poke_busy", o_busy, 1);
      end
    end
    if (idx == 4) begin
      r_dout1 = 512'((op_a1[63:0] * op_b1[63:0]) % op_m1[63:0]);
      r_dout2 = 512'((op_a2[63:0] * op_b2[63:0]) % op_m2[63:0]);
      r_d1v = 1'b1;
      r_d2v = 1'b1;
      n = 0;
      while (o_dread !== 1'b1 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("dout_read", o_dread, 1);
      r_d1v = 1'b0;
      r_d2v = 1'b0;
      @(negedge clk);
      chk("dout_read_pulse", o_dread, 0);
    end
    if (lat >= 0) begin
      repeat (lat) @(negedge clk);
      r_p2v = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (o_p2r !== 1'b1 && n < 300);
      chk("p2_ack", o_p2r, 1);
      if (idx < 3) chk("din_drop", o_dinv, 0);
      repeat (hold) @(negedge clk);
      r_p2v = 1'b0;
    end
  endtask

  task automatic run(input int bdelay, input int hold, input int mul,
                     input bit poke, input int e1, input int e2);
    int d0, c0, p0, cb, n;
    d0 = done_cnt;
    c0 = cmd_cnt;
    p0 = p2r_cnt;
    pulse_start();
    chk("busy_on", o_busy, 1);
    chk("p1v_on", o_p1v, 1);
    chk("err_clear", o_err, 0);
    serve(0, 0, 2, hold, poke);
    cb = cmd_cnt;
    serve(1, bdelay, 2, hold, 1'b0);
    chk("one_cmd_b", 512'(cmd_cnt - cb), 1);
    serve(2, 0, 2, hold, 1'b0);
    serve(3, 0, mul, hold, 1'b0);
    serve(4, 0, 1, hold, 1'b0);
    n = 0;
    while (done_cnt == d0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("done_once", 512'(done_cnt - d0), 1);
    chk("busy_off", o_busy, 0);
    chk("err_off", o_err, 0);
    chk("res1", o_res1, 512'(e1));
    chk("res2", o_res2, 512'(e2));
    chk("cmd_count", 512'(cmd_cnt - c0), 5);
    chk("p2r_count", 512'(p2r_cnt - p0), 5);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_p1v", o_p1v, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_dout", o_p1_dout, 0);
    chk("rst_res1", o_res1, 0);
    chk("rst_din1", o_din1, 0);
    chk("rst_p2r", o_p2r, 0);
    reset = 1'b0;
    @(negedge clk);

    sel = 1'b0;
    set_ops(3, 5, 7, 10, 11, 13);
    run(0, 0, 100, 1'b0, 1, 6);

    set_ops(6, 9, 11, 20, 30, 17);
    run(20, 3, 5, 1'b0, 10, 5);

    sel = 1'b1;
    @(negedge clk);
    set_ops(3, 5, 7, 10, 11, 13);
    run(0, 0, 10, 1'b0, 1, 6);

    set_ops(4, 5, 7, 10, 11, 13);
    pulse_start();
    serve(0, 0, 2, 0, 1'b0);
    serve(1, 0, 2, 0, 1'b0);
    serve(2, 0, 2, 0, 1'b0);
    serve(3, 0, -1, 0, 1'b0);
    n = 0;
    while (o_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 512'(n), 51);
    chk("tmo_err", o_err, 1);
    @(negedge clk);
    chk("tmo_busy", o_busy, 0);
    chk("tmo_p1v", o_p1v, 0);
    chk("tmo_err_hold", o_err, 1);
    chk("tmo_res1", o_res1, 1);
    chk("tmo_res2", o_res2, 6);

    run(0, 0, 10, 1'b1, 6, 6);

    sel = 1'b0;
    @(negedge clk);
    set_ops(2, 8, 5, 7, 8, 9);
    pulse_start();
    serve(0, 0, 2, 0, 1'b0);
    serve(1, 0, 2, 0, 1'b0);
    serve(2, 0, 2, 0, 1'b0);
    serve(3, 0, 5, 0, 1'b0);
    n = 0;
    while (o_p1v !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("w_cmd", o_p1_dout, 4);
    r_p1_read = 1'b1;
    @(negedge clk);
    r_p1_read = 1'b0;
    repeat (2) @(negedge clk);
    r_dout1 = 512'd3;
    r_dout2 = 512'd3;
    r_d1v = 1'b1;
    r_d2v = 1'b1;
    @(negedge clk);
    chk("pre_rst_read", o_dread, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_dread", o_dread, 0);
    chk("async_busy", o_busy, 0);
    chk("async_p1v", o_p1v, 0);
    r_d1v = 1'b0;
    r_d2v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("async_res1", o_res1, 0);
    @(negedge clk);
    run(0, 0, 4, 1'b0, 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule

// File: doc/mont_host_driver.md
# mont_host_driver

Hardware initiator for the Montgomery wrapper command protocol, replacing the ARM-side driver in bare-logic test systems and self-checking builds. On one `start` pulse it latches two independent operand sets (A, B, M for core 1 and core 2) and runs the full command sequence READ_A, READ_B, READ_M, MULTIPLY, WRITE over port1/port2/BRAM handshakes. It then returns both 512-bit results with a `done` pulse.

## Interface
- `TIMEOUT_CYCLES`, default 65535: maximum cycles spent in any single wait state before aborting.
- `clk` in 1: system clock; all logic is rising-edge.
- `reset` in 1: asynchronous reset, active high.
- `start` in 1: one-cycle request; ignored while `busy`=1.
- `a1`, `a2`, `b1`, `b2`, `m1`, `m2` in 512 each: operands; latched on accepted `start`.
- `res1`, `res2` out 512 each: results; hold their value until the next capture.
- `done` out 1: one-cycle pulse when results are valid or on abort.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `err` out 1: sticky timeout flag; cleared on the next accepted `start`.
- `port1_dout` out 32: command word (0 READ_A, 1 READ_B, 2 READ_M, 3 MULTIPLY, 4 WRITE).
- `port1_valid` out 1: command valid.
- `port1_read` in 1: responder has consumed the command.
- `bram_din1`, `bram_din2` out 512 each: operand pair for the current READ command.
- `bram_din_valid` out 1: operand pair valid.
- `bram_dout1`, `bram_dout2` in 512 each: result pair from the responder.
- `bram_dout1_valid`, `bram_dout2_valid` in 1 each: result pair valid.
- `bram_dout_read` out 1: one-cycle acknowledge of the result pair.
- `port2_valid` in 1: responder signals that the command is done.
- `port2_read` out 1: one-cycle acknowledge of `port2_valid`.

## Operation
- States: IDLE, CMD, DATA, WAITDONE, RESULT, P2ACK, P2LOW, FIN.
- Command index `cmd_idx` runs 0→4; `port1_dout` equals `cmd_idx`.
- IDLE, `start`=1: latch the six operands, set `cmd_idx`=0, clear `err`, go to CMD.
- CMD: hold `port1_valid`=1 until `port1_read`=1 is seen, then drop `port1_valid` next edge.
  - Next state for `cmd_idx` 0-2: DATA.
  - Next state for `cmd_idx` 3: WAITDONE.
  - Next state for `cmd_idx` 4: RESULT.
- DATA: drive `bram_din1/2` with the pair selected by `cmd_idx` (A, B or M) and `bram_din_valid`=1. Hold until `port2_valid`=1, then go to P2ACK; `bram_din_valid` drops on the same edge.
- WAITDONE: wait for `port2_valid`=1, then go to P2ACK.
- RESULT: wait until both `bram_dout1_valid` and `bram_dout2_valid` are 1.
  - Capture `res1`←`bram_dout1` and `res2`←`bram_dout2`.
  - Pulse `bram_dout_read` for one cycle, then wait for `port2_valid`=1 and go to P2ACK.
- P2ACK: `port2_read`=1 for exactly one cycle, then go to P2LOW.
- P2LOW: wait for `port2_valid`=0, which guards against the responder's registered one-cycle-late deassert.
  - If `cmd_idx`<4: increment `cmd_idx` and go to CMD.
  - If `cmd_idx`=4: go to FIN.
- FIN: `done`=1 for one cycle, then go to IDLE.
- Timeout: a 17-bit counter clears on every state change and increments in CMD, DATA, WAITDONE, RESULT and P2LOW.
  - When the counter reaches `TIMEOUT_CYCLES`, set `err`=1, drop all handshake outputs and go to FIN.
  - `res1`/`res2` are not updated on abort.
- `start` while `busy` is dropped; there is no queueing.
- Reset mid-sequence: every output returns to its reset value immediately (asynchronous), and the FSM returns to IDLE.

## Timing
- Reset values: `port1_valid`, `bram_din_valid`, `bram_dout_read`, `port2_read`, `done`, `busy` and `err` are all 0; `port1_dout`=0; `res1`, `res2`, `bram_din1` and `bram_din2` are all 0.
- All outputs are registered; no input reaches an output combinationally.
- `start` sampled at edge 0 gives `busy`=1 and `port1_valid`=1 after edge 0.
- `port1_read` seen at edge n gives `port1_valid`=0 after edge n.
- `port2_valid` seen at edge n gives `port2_read`=1 during cycle n+1 only.
- `port2_valid`=0 seen at edge k with `cmd_idx`<4 gives the next `port1_valid`=1 after edge k+1.
- `port2_valid` held high forever after P2ACK causes a timeout in P2LOW, never a second acknowledge.
- With an ideal responder (1-cycle read, 1-cycle done), the protocol overhead per command is at most 7 cycles.

## Test plan
- Nominal run: responder model, multiply latency 100 cycles, `a1`=3, `b1`=5, `m1`=7, model result = a·b mod m. Required: commands seen in order 0,1,2,3,4; `res1`=1 and `res2` correct; one `done` pulse; `err`=0.
- Handshake hold: delay `port1_read` by 20 cycles on READ_B. Required: `port1_valid` stays high and `port1_dout`=1 for all 20 cycles, and exactly one command is seen.
- Late `port2_valid` deassert: responder holds `port2_valid` 3 extra cycles. Required: exactly one `port2_read` pulse per command and no command is skipped.
- Timeout: `TIMEOUT_CYCLES`=50, multiply never completes. Required: `done` pulse about 51 cycles after the MULTIPLY handshake, `err`=1, `res1`/`res2` unchanged, `busy`=0.
- Busy/restart: `start` pulsed during DATA, then after `done`. Required: the first extra `start` is ignored; the second clears `err` and runs the sequence again.
- Asynchronous `reset` asserted mid-RESULT, between clock edges. Required: `bram_dout_read`, `busy` and `port1_valid` are 0 immediately, and a following `start` completes normally.
